// File: rtl/parity_pkg.sv
// Shared types and constants for the parity frame receiver.
// Used by parity_chk and parity_frame_rx (optional feature macro: PARITY_ERR_CNT_EN).
package parity_pkg;

  // Receiver FSM states
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Parity check mode encodings
  localparam logic PAR_ODD  = 1'b1;
  localparam logic PAR_EVEN = 1'b0;

  // Default frame geometry: DATA_W data bits plus one parity bit at the MSB
  localparam int DEF_DATA_W  = 7;
  localparam int DEF_FRAME_W = DEF_DATA_W + 1;

  // Frame width for a given number of data bits
  function automatic int frame_w(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/parity_chk.sv
// Combinational parity checker for one frame.
// frame[DATA_W] is the received parity bit, frame[DATA_W-1:0] the data.
// err = 1 when the frame does not satisfy the selected parity mode.
module parity_chk
  import parity_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W:0] frame,
  input  logic            mode,
  output logic            err
);

  logic data_x;

  // Fold the data bits, then compare against the received parity bit
  always_comb begin
    data_x = ^frame[DATA_W-1:0];
    if (mode == PAR_ODD) begin
      // Odd parity: parity bit must be the inverse of the data XOR
      err = (frame[DATA_W] == data_x);
    end else begin
      // Even parity: parity bit must equal the data XOR
      err = (frame[DATA_W] != data_x);
    end
  end

endmodule

// File: rtl/parity_frame_rx.sv
// Serial-to-parallel frame receiver with parity check and a one-frame
// holding register on a valid/ready output.
// Frames arrive LSB first, DATA_W data bits followed by the parity bit.
// Optional feature macro: PARITY_ERR_CNT_EN adds the saturating err_cnt output.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a bit_vld qualified by frm_start (bit 0)
// SHIFT | collecting bits 1..DATA_W; bit DATA_W completes the frame
module parity_frame_rx
  import parity_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter bit ODD_PARITY = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_vld,
  input  logic              bit_in,
  input  logic              frm_start,
  input  logic              out_rdy,
  input  logic              ovf_clr,
  output logic              out_vld,
  output logic [DATA_W:0]   out_data,
  output logic              par_err,
  output logic              ovf
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int FRAME_W = frame_w(DATA_W);
  // Counter only needs to reach DATA_W, the index of the parity bit
  localparam int CNT_W = (FRAME_W > 2) ? $clog2(FRAME_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] FIRST_CNT = CNT_W'(1);
  localparam logic CHK_MODE = ODD_PARITY ? PAR_ODD : PAR_EVEN;

  // Receiver state
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic               frame_done;
  logic               frame_err;

  // Holding register and status
  logic               out_vld_q, out_vld_d;
  logic [FRAME_W-1:0] out_data_q, out_data_d;
  logic               par_err_q, par_err_d;
  logic               ovf_q, ovf_d;
  logic               load;
  logic               drain;

  // Receiver FSM, bit counter and shift register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // Next-state: frm_start always restarts a frame, even mid-frame
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    frame_done = 1'b0;
    if (bit_vld) begin
      if (frm_start) begin
        // Partial frame (if any) is silently abandoned
        state_d    = SHIFT;
        cnt_d      = FIRST_CNT;
        shift_d    = '0;
        shift_d[0] = bit_in;
      end else if (state_q == SHIFT) begin
        shift_d[cnt_q] = bit_in;
        if (cnt_q == LAST_CNT) begin
          frame_done = 1'b1;
          state_d    = IDLE;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // Check the frame as it will look once the parity bit is shifted in
  parity_chk #(
    .DATA_W (DATA_W)
  ) u_parity_chk (
    .frame (shift_d),
    .mode  (CHK_MODE),
    .err   (frame_err)
  );

  // Holding register and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      par_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      par_err_q  <= par_err_d;
      ovf_q      <= ovf_d;
    end
  end

  // Load when empty or draining this cycle; otherwise a completed frame is dropped
  always_comb begin
    drain      = out_vld_q & out_rdy;
    load       = frame_done & (~out_vld_q | out_rdy);
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    par_err_d  = par_err_q;
    if (load) begin
      out_vld_d  = 1'b1;
      out_data_d = shift_d;
      par_err_d  = frame_err;
    end else if (drain) begin
      out_vld_d = 1'b0;
    end
    // Clear first so a drop in the same cycle keeps the flag set
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (frame_done && !load) begin
      ovf_d = 1'b1;
    end
  end

`ifdef PARITY_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [7:0] err_cnt_base;

  // Saturating count of erroneous frames that reached the holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  // Clear and count in the same cycle: the new error counts from zero
  always_comb begin
    err_cnt_base = ovf_clr ? 8'd0 : err_cnt_q;
    err_cnt_d    = err_cnt_base;
    if (load && frame_err && (err_cnt_base != 8'hFF)) begin
      err_cnt_d = err_cnt_base + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign par_err  = par_err_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx: an odd-parity and an even-parity
// instance share one stimulus stream; expected frames are queued when a
// frame is sent and checked when the holding register presents it.
module tb_parity_frame_rx;

  localparam int DW = 7;

  logic clk = 1'b0;
  logic rst_n, bit_vld, bit_in, frm_start, out_rdy, ovf_clr;
  logic out_vld, par_err, ovf;
  logic [DW:0] out_data;
  logic e_out_vld, e_par_err, e_ovf;
  logic [DW:0] e_out_data;
`ifdef PARITY_ERR_CNT_EN
  logic [7:0] err_cnt, e_err_cnt;
`endif

  always #5 clk = ~clk;

  parity_frame_rx #(.DATA_W(DW), .ODD_PARITY(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bit_vld(bit_vld), .bit_in(bit_in),
    .frm_start(frm_start), .out_rdy(out_rdy), .ovf_clr(ovf_clr),
    .out_vld(out_vld), .out_data(out_data), .par_err(par_err), .ovf(ovf)
`ifdef PARITY_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  parity_frame_rx #(.DATA_W(DW), .ODD_PARITY(1'b0)) dut_even (
    .clk(clk), .rst_n(rst_n), .bit_vld(bit_vld), .bit_in(bit_in),
    .frm_start(frm_start), .out_rdy(out_rdy), .ovf_clr(ovf_clr),
    .out_vld(e_out_vld), .out_data(e_out_data), .par_err(e_par_err), .ovf(e_ovf)
`ifdef PARITY_ERR_CNT_EN
    , .err_cnt(e_err_cnt)
`endif
  );

  typedef struct packed {
    logic [7:0] frame;
    logic       err_odd;
    logic       err_even;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passes = 0;
  int exp_err_cnt = 0;
  bit rdy_on_last = 1'b0;
  bit clr_on_last = 1'b0;
  bit watch_vld = 1'b0;
  bit gap_seen = 1'b0;

  always @(negedge clk) if (watch_vld && !out_vld) gap_seen = 1'b1;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Expected result from the total count of ones in the frame
  function automatic exp_t model(input logic [7:0] f);
    exp_t e;
    int ones;
    ones       = $countones(f);
    e.frame    = f;
    e.err_odd  = ((ones % 2) == 0);
    e.err_even = ((ones % 2) == 1);
    return e;
  endfunction

  task automatic send_bit(input logic b, input logic start, input bit last);
    @(negedge clk);
    bit_vld   = 1'b1;
    bit_in    = b;
    frm_start = start;
    if (last) begin
      if (rdy_on_last) out_rdy = 1'b1;
      ovf_clr = clr_on_last;
    end
    @(negedge clk);
    bit_vld   = 1'b0;
    frm_start = 1'b0;
    bit_in    = 1'b0;
    ovf_clr   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f, input int max_gap, input bit loaded);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_bit(f[i], (i == 0), (i == 7));
    end
    if (clr_on_last) exp_err_cnt = 0;
    if (loaded) begin
      e = model(f);
      sb.push_back(e);
      if (e.err_odd && exp_err_cnt < 255) exp_err_cnt++;
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    exp_err_cnt = 0;
  endtask

  task automatic expect_frame(input string tag);
    exp_t e;
    int waited;
    waited = 0;
    while (!out_vld && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, " latency"}, waited, 0);
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty", tag);
      $fatal(1, "scoreboard underflow");
    end
    e = sb.pop_front();
    chk({tag, " out_vld"}, out_vld, 1);
    chk({tag, " out_data"}, out_data, e.frame);
    chk({tag, " par_err odd"}, par_err, e.err_odd);
    chk({tag, " out_data even"}, e_out_data, e.frame);
    chk({tag, " par_err even"}, e_par_err, e.err_even);
  endtask

  initial begin
    rst_n = 1'b0; bit_vld = 1'b0; bit_in = 1'b0; frm_start = 1'b0;
    out_rdy = 1'b0; ovf_clr = 1'b0;
    #12;
    chk("reset out_vld", out_vld, 0);
    chk("reset out_data", out_data, 0);
    chk("reset par_err", par_err, 0);
    chk("reset ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_rdy = 1'b1;

    // Stray bits without frm_start are ignored in IDLE
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    chk("stray out_vld", out_vld, 0);

    send_frame(8'h01, 0, 1'b1); expect_frame("f01");
    send_frame(8'h81, 2, 1'b1); expect_frame("f81");
    send_frame(8'h03, 1, 1'b1); expect_frame("f03");
    send_frame(8'h83, 3, 1'b1); expect_frame("f83");
    @(negedge clk);
    chk("drain out_vld", out_vld, 0);

    // Backpressure: second frame is dropped, held frame untouched
    out_rdy = 1'b0;
    send_frame(8'h55, 1, 1'b1); expect_frame("bp55");
    send_frame(8'h2A, 1, 1'b0);
    chk("bp held data", out_data, 8'h55);
    chk("bp held vld", out_vld, 1);
    chk("bp ovf", ovf, 1);
    out_rdy = 1'b1;
    @(negedge clk);
    chk("bp drained vld", out_vld, 0);
    chk("bp data holds", out_data, 8'h55);
    chk("bp ovf sticky", ovf, 1);
    pulse_clr();
    chk("bp ovf cleared", ovf, 0);

    // Simultaneous drain and load: no bubble on out_vld
    out_rdy = 1'b0;
    send_frame(8'h10, 1, 1'b1); expect_frame("sim10");
    gap_seen = 1'b0;
    watch_vld = 1'b1;
    rdy_on_last = 1'b1;
    send_frame(8'h7F, 2, 1'b1);
    rdy_on_last = 1'b0;
    expect_frame("sim7F");
    watch_vld = 1'b0;
    chk("sim no bubble", gap_seen, 0);
    chk("sim ovf", ovf, 0);
    @(negedge clk);
    chk("sim drained", out_vld, 0);

    // Abort: partial frame replaced by a new frm_start
    out_rdy = 1'b1;
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    chk("abort partial vld", out_vld, 0);
    send_frame(8'h40, 1, 1'b1); expect_frame("abort40");
    @(negedge clk);
    chk("abort no extra", out_vld, 0);
    chk("abort ovf", ovf, 0);

    // Overflow set and clear in the same cycle: set wins
    out_rdy = 1'b0;
    send_frame(8'h11, 0, 1'b1); expect_frame("sw11");
    clr_on_last = 1'b1;
    send_frame(8'h22, 0, 1'b0);
    clr_on_last = 1'b0;
    chk("setwins ovf", ovf, 1);
    chk("setwins held", out_data, 8'h11);
    out_rdy = 1'b1;
    pulse_clr();
    chk("setwins cleared", ovf, 0);
    chk("setwins drained", out_vld, 0);

    // Random frames with random gaps
    for (int n = 0; n < 6; n++) begin
      send_frame(8'($urandom_range(0, 255)), 3, 1'b1);
      expect_frame("rand");
    end
    @(negedge clk);

`ifdef PARITY_ERR_CNT_EN
    chk("err_cnt odd", err_cnt, exp_err_cnt);
`endif

    // Reset mid-frame with a held frame and ovf set
    out_rdy = 1'b0;
    send_frame(8'h01, 0, 1'b1); expect_frame("rh01");
    send_frame(8'h02, 0, 1'b0);
    chk("pre-reset ovf", ovf, 1);
    send_bit(1'b0, 1'b1, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst out_vld", out_vld, 0);
    chk("midrst out_data", out_data, 0);
    chk("midrst par_err", par_err, 0);
    chk("midrst ovf", ovf, 0);
    exp_err_cnt = 0;
`ifdef PARITY_ERR_CNT_EN
    chk("midrst err_cnt", err_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    out_rdy = 1'b1;
    send_frame(8'h01, 1, 1'b1); expect_frame("post01");
    send_frame(8'h81, 0, 1'b1); expect_frame("post81");
    @(negedge clk);

`ifdef PARITY_ERR_CNT_EN
    chk("err_cnt final", err_cnt, exp_err_cnt);
`endif
    chk("sb empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
